// File: rtl/wb_stage.sv
// Writeback stage: retires the MEM-stage instruction into the register file write port,
// waiting for data-memory read data on loads and formatting it before the write.
module wb_stage #(
    parameter int unsigned RegBusWidth  = 32,
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    mem_valid_i,
    input  logic [RegAddrWidth-1:0] mem_rd_i,
    input  logic                    mem_we_i,
    input  logic                    mem_is_load_i,
    input  logic [2:0]              mem_funct3_i,
    input  logic [1:0]              mem_addr_lo_i,
    input  logic [RegBusWidth-1:0]  mem_result_i,
    input  logic                    dm_rvalid_i,
    input  logic [RegBusWidth-1:0]  dm_rdata_i,
    output logic                    wb_stall_o,
    output logic                    we_o,
    output logic [RegAddrWidth-1:0] waddr_o,
    output logic [RegBusWidth-1:0]  wdata_o
);

    typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

    state_e                  state_q, state_d;
    logic [RegAddrWidth-1:0] rd_q, rd_d;
    logic                    ld_we_q, ld_we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              addr_lo_q, addr_lo_d;
    logic                    we_q, we_d;
    logic [RegAddrWidth-1:0] waddr_q, waddr_d;
    logic [RegBusWidth-1:0]  wdata_q, wdata_d;

    logic                    capture;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [RegBusWidth-1:0]  load_data;

    assign capture    = (state_q == StIdle) & mem_valid_i & ~stall_i & ~flush_i;
    assign wb_stall_o = (state_q == StWaitLoad) & ~dm_rvalid_i;

    // Lane selection uses the held address; addr_lo[0] is irrelevant for halves.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_q)
            2'd0:    byte_sel = dm_rdata_i[7:0];
            2'd1:    byte_sel = dm_rdata_i[15:8];
            2'd2:    byte_sel = dm_rdata_i[23:16];
            default: byte_sel = dm_rdata_i[31:24];
        endcase
        half_sel = addr_lo_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    end

    always_comb begin
        load_data = dm_rdata_i;
        case (funct3_q)
            3'b000:  load_data = {{(RegBusWidth-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(RegBusWidth-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(RegBusWidth-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(RegBusWidth-16){1'b0}}, half_sel};
            default: load_data = dm_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        ld_we_d   = ld_we_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        case (state_q)
            StIdle: begin
                if (capture) begin
                    if (mem_is_load_i) begin
                        rd_d      = mem_rd_i;
                        ld_we_d   = mem_we_i;
                        funct3_d  = mem_funct3_i;
                        addr_lo_d = mem_addr_lo_i;
                        state_d   = StWaitLoad;
                    end else if (mem_we_i && (mem_rd_i != '0)) begin
                        we_d    = 1'b1;
                        waddr_d = mem_rd_i;
                        wdata_d = mem_result_i;
                    end
                end
            end
            StWaitLoad: begin
                // The pending load is older than any flush, so only the response matters here.
                if (dm_rvalid_i) begin
                    we_d    = ld_we_q && (rd_q != '0);
                    waddr_d = rd_q;
                    wdata_d = load_data;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            rd_q      <= '0;
            ld_we_q   <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            ld_we_q   <= ld_we_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule
